// File: rtl/mmb_address_demux_if.sv
// Purpose: bundles the upstream MMB master link and the SLAVES downstream links of the address demux.
// Latency: none, this is wiring only.
// Backpressure: s_busy carries the demux stall upstream; m_busy carries each slave's stall into the demux.
//
// Ports (signals):
//   s_addr/s_bcnt/s_wreq/s_wdat/s_rreq  upstream request (master -> demux)
//   s_rdat/s_rval/s_busy                upstream response (demux -> master)
//   m_addr/m_bcnt/m_wreq/m_wdat/m_rreq  per-slave request, packed [SLAVES] arrays (demux -> slaves)
//   m_rdat/m_rval/m_busy                per-slave response (slaves -> demux)
// Modports: slave = the demux view (it is the slave of the upstream master),
//           master = the environment view (upstream master plus downstream slaves).
interface mmb_address_demux_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int BWIDTH = 4,
  parameter int SLAVES = 4
);
  // upstream link
  logic [AWIDTH-1:0]              s_addr;
  logic [BWIDTH-1:0]              s_bcnt;
  logic                           s_wreq;
  logic [DWIDTH-1:0]              s_wdat;
  logic                           s_rreq;
  logic [DWIDTH-1:0]              s_rdat;
  logic                           s_rval;
  logic                           s_busy;

  // downstream links, one slot per slave
  logic [SLAVES-1:0][AWIDTH-1:0]  m_addr;
  logic [SLAVES-1:0][BWIDTH-1:0]  m_bcnt;
  logic [SLAVES-1:0]              m_wreq;
  logic [SLAVES-1:0][DWIDTH-1:0]  m_wdat;
  logic [SLAVES-1:0]              m_rreq;
  logic [SLAVES-1:0][DWIDTH-1:0]  m_rdat;
  logic [SLAVES-1:0]              m_rval;
  logic [SLAVES-1:0]              m_busy;

  modport slave (
    input  s_addr, s_bcnt, s_wreq, s_wdat, s_rreq,
    output s_rdat, s_rval, s_busy,
    output m_addr, m_bcnt, m_wreq, m_wdat, m_rreq,
    input  m_rdat, m_rval, m_busy
  );

  modport master (
    output s_addr, s_bcnt, s_wreq, s_wdat, s_rreq,
    input  s_rdat, s_rval, s_busy,
    input  m_addr, m_bcnt, m_wreq, m_wdat, m_rreq,
    output m_rdat, m_rval, m_busy
  );
endinterface

// File: rtl/mmb_address_demux.sv
// Purpose: routes one MMB burst master to SLAVES burst slaves selected by the top address bits.
// Latency: request path and read-return path are combinational (zero cycles).
// Backpressure: s_busy follows the selected slave's m_busy; forced high for reads that would reorder,
//               exceed RDPENDS outstanding, or arrive during a write burst.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears the write FSM and all read tracking
//   bus    mmb_address_demux_if.slave: s_* upstream link, m_* packed per-slave links
module mmb_address_demux #(
  parameter int AWIDTH  = 8,
  parameter int DWIDTH  = 8,
  parameter int BWIDTH  = 4,
  parameter int SLAVES  = 4,
  parameter int RDPENDS = 2
) (
  input  logic                clk,
  input  logic                reset,
  mmb_address_demux_if.slave  bus
);

  localparam int SELW = $clog2(SLAVES);
  localparam int LENW = BWIDTH + 1;                            // burst length 1..2^BWIDTH
  localparam int PTRW = (RDPENDS > 1) ? $clog2(RDPENDS) : 1;
  localparam int CNTW = $clog2(RDPENDS + 1);
  localparam int RWW  = $clog2(RDPENDS * (2 ** BWIDTH) + 1);   // worst-case outstanding words

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  // write burst tracking
  state_t              state, state_nxt;
  logic [SELW-1:0]     wsel, wsel_nxt;
  logic [BWIDTH-1:0]   wcnt, wcnt_nxt;

  // read tracking: slave owning the outstanding reads, per-burst remaining words, total words
  logic [SELW-1:0]     rsel;
  logic [LENW-1:0]     fifo_len [RDPENDS];
  logic [PTRW-1:0]     rd_ptr;
  logic [PTRW-1:0]     wr_ptr;
  logic [CNTW-1:0]     fifo_cnt;
  logic [RWW-1:0]      rwords;

  logic [SELW-1:0]     addr_idx;
  logic [SELW-1:0]     target;
  logic                tgt_busy;
  logic                fifo_full;
  logic                rd_allowed;
  logic                wr_acc;
  logic                rd_acc;
  logic                rval_out;
  logic                head_last;
  logic                push;
  logic                pop;
  logic [LENW-1:0]     burst_len;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    if (p == PTRW'(RDPENDS - 1)) return '0;
    return p + PTRW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Routing and admission
  // ---------------------------------------------------------------------------
  assign addr_idx  = bus.s_addr[AWIDTH-1 -: SELW];
  // Once a write burst is locked, later beats ignore their address for routing.
  assign target    = (state == WRITE) ? wsel : addr_idx;
  assign tgt_busy  = bus.m_busy[target];
  assign fifo_full = (fifo_cnt == CNTW'(RDPENDS));  // pre-pop count: a pop does not free a slot this cycle

  // Reads are admitted only in IDLE, never alongside a write, and only to the slave
  // that already owns the outstanding read data so returns stay in request order.
  assign rd_allowed = bus.s_rreq & ~bus.s_wreq & (state == IDLE) & ~fifo_full &
                      ((rwords == '0) | (addr_idx == rsel));

  assign wr_acc = bus.s_wreq & ~tgt_busy;
  assign rd_acc = rd_allowed & ~tgt_busy;

  always_comb begin
    bus.m_wreq = '0;
    bus.m_rreq = '0;
    bus.m_addr = '0;
    bus.m_bcnt = '0;
    bus.m_wdat = '0;
    for (int i = 0; i < SLAVES; i++) begin
      bus.m_wreq[i] = bus.s_wreq & (target == SELW'(i));
      bus.m_rreq[i] = rd_allowed & (target == SELW'(i));
      bus.m_addr[i] = bus.s_addr;
      bus.m_bcnt[i] = bus.s_bcnt;
      bus.m_wdat[i] = bus.s_wdat;
    end
  end

  always_comb begin
    bus.s_busy = 1'b0;
    if (bus.s_wreq) begin
      bus.s_busy = tgt_busy;
    end else if (bus.s_rreq) begin
      bus.s_busy = rd_allowed ? tgt_busy : 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Write burst FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    wsel_nxt  = wsel;
    wcnt_nxt  = wcnt;
    case (state)
      IDLE: begin
        if (wr_acc && (bus.s_bcnt != '0)) begin
          state_nxt = WRITE;
          wsel_nxt  = addr_idx;
          wcnt_nxt  = bus.s_bcnt;
        end
      end
      WRITE: begin
        if (wr_acc) begin
          wcnt_nxt = wcnt - BWIDTH'(1);
          if (wcnt == BWIDTH'(1)) begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      wsel  <= '0;
      wcnt  <= '0;
    end else begin
      state <= state_nxt;
      wsel  <= wsel_nxt;
      wcnt  <= wcnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Read return path
  // ---------------------------------------------------------------------------
  // Valid from a slave is only honoured while words are owed; this also drops
  // stray returns that arrive after a reset cleared the bookkeeping.
  assign rval_out   = bus.m_rval[rsel] & (rwords != '0);
  assign bus.s_rval = rval_out;
  assign bus.s_rdat = bus.m_rdat[rsel];

  assign burst_len = LENW'(bus.s_bcnt) + LENW'(1);
  assign head_last = (fifo_len[rd_ptr] == LENW'(1));
  assign push      = rd_acc;
  assign pop       = rval_out & head_last;

  // push writes wr_ptr and the head update writes rd_ptr; they can only alias
  // when the queue is empty (no rval_out) or full (no push), so never together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsel     <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
      rwords   <= '0;
      for (int i = 0; i < RDPENDS; i++) begin
        fifo_len[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo_len[wr_ptr] <= burst_len;
        wr_ptr           <= ptr_inc(wr_ptr);
        rsel             <= addr_idx;
      end

      if (rval_out) begin
        if (head_last) begin
          rd_ptr <= ptr_inc(rd_ptr);
        end else begin
          fifo_len[rd_ptr] <= fifo_len[rd_ptr] - LENW'(1);
        end
      end

      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNTW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNTW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase

      rwords <= rwords + (push ? RWW'(burst_len) : RWW'(0)) - (rval_out ? RWW'(1) : RWW'(0));
    end
  end

endmodule

// File: tb/tb_mmb_address_demux.sv
// Bench for mmb_address_demux: table-driven routing vectors, hand sequences for
// bursts, ordering, pending limit and reset, and a read-data scoreboard fed by a slave model.
module tb_mmb_address_demux;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int BW = 4;
  localparam int SL = 4;
  localparam int RP = 2;

  logic clk;
  logic reset;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mmb_address_demux_if #(.AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .SLAVES(SL)) bus ();

  mmb_address_demux #(
    .AWIDTH(AW), .DWIDTH(DW), .BWIDTH(BW), .SLAVES(SL), .RDPENDS(RP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int rval_seen = 0;

  typedef struct packed {
    logic [1:0]    slv;
    logic [DW-1:0] dat;
  } rsp_t;

  rsp_t          rsp_q[$];   // words the slave model still has to return, in issue order
  logic [DW-1:0] sb_q[$];    // read data the master expects, in request order
  rsp_t          cur;
  logic [DW-1:0] exp_d;
  logic [5:0]    tag;
  bit            rsp_en;

  typedef struct {
    logic [AW-1:0] addr;
    logic          wreq;
    logic          rreq;
    logic [SL-1:0] mbusy;
    logic [SL-1:0] ew;
    logic [SL-1:0] er;
    logic          eb;
  } vec_t;

  vec_t vecs[10];

  task automatic check(string n, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  task automatic check_req(string n, logic [SL-1:0] ew, logic [SL-1:0] er, logic eb);
    check({n, "_wreq"}, 32'(bus.m_wreq), 32'(ew));
    check({n, "_rreq"}, 32'(bus.m_rreq), 32'(er));
    check({n, "_busy"}, 32'(bus.s_busy), 32'(eb));
  endtask

  task automatic drive(logic [AW-1:0] a, logic [BW-1:0] c, logic w, logic r, logic [DW-1:0] d);
    bus.s_addr = a;
    bus.s_bcnt = c;
    bus.s_wreq = w;
    bus.s_rreq = r;
    bus.s_wdat = d;
  endtask

  task automatic idle_in();
    drive('0, '0, 1'b0, 1'b0, '0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string n);
    int k = 0;
    while ((sb_q.size() != 0 || rsp_q.size() != 0) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({n, "_drained"}, 32'(sb_q.size() + rsp_q.size()), 32'd0);
    next_cycle();
  endtask

  // Slave model, request side: an accepted read queues its words and the expected data.
  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SL; i++) begin
        if (bus.m_rreq[i] && !bus.m_busy[i]) begin
          for (int w = 0; w <= int'(bus.m_bcnt[i]); w++) begin
            rsp_q.push_back({2'(i), {2'(i), tag}});
            sb_q.push_back({2'(i), tag});
            tag++;
          end
        end
      end
    end
  end

  // Slave model, return side: one word per cycle while enabled; idle slaves drive zero.
  initial begin
    bus.m_rval = '0;
    bus.m_rdat = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_rval = '0;
      bus.m_rdat = '0;
      if (rsp_en && rsp_q.size() > 0) begin
        cur = rsp_q.pop_front();
        bus.m_rval[cur.slv] = 1'b1;
        bus.m_rdat[cur.slv] = cur.dat;
      end
    end
  end

  // Master-side monitor: every returned word must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.s_rval) begin
      rval_seen++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rval_unexpected actual=%0h required=no_rval", bus.s_rdat);
      end else begin
        exp_d = sb_q.pop_front();
        check("rdata", 32'(bus.s_rdat), 32'(exp_d));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall;
    logic leak;

    tag    = '0;
    rsp_en = 1'b1;
    reset  = 1'b1;
    bus.m_busy = '0;
    idle_in();

    //              addr   w     r     mbusy    exp_w    exp_r    exp_busy
    vecs[0] = '{8'h00, 1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 1'b0};
    vecs[1] = '{8'h45, 1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[2] = '{8'h80, 1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 1'b1};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 4'b0111, 4'b1000, 4'b0000, 1'b0};
    vecs[4] = '{8'h10, 1'b0, 1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b1};
    vecs[5] = '{8'hC3, 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b1};
    vecs[6] = '{8'h55, 1'b1, 1'b1, 4'b0000, 4'b0010, 4'b0000, 1'b0};
    vecs[7] = '{8'h55, 1'b1, 1'b1, 4'b0010, 4'b0010, 4'b0000, 1'b1};
    vecs[8] = '{8'h00, 1'b0, 1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0};
    vecs[9] = '{8'hA0, 1'b0, 1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1};

    // Reset state with no requests present
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_req("reset", 4'b0000, 4'b0000, 1'b0);
    check("reset_rval", 32'(bus.s_rval), 32'd0);
    check("reset_rdat", 32'(bus.s_rdat), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    next_cycle();

    // Single-cycle routing vectors (bcnt = 0, busy targets block read acceptance)
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].addr, 4'd0, vecs[i].wreq, vecs[i].rreq, DW'(8'h5A ^ i));
      bus.m_busy = vecs[i].mbusy;
      @(negedge clk);
      check_req($sformatf("v%0d", i), vecs[i].ew, vecs[i].er, vecs[i].eb);
      check($sformatf("v%0d_addr", i), bus.m_addr, {SL{vecs[i].addr}});
      check($sformatf("v%0d_wdat", i), bus.m_wdat, {SL{DW'(8'h5A ^ i)}});
      check($sformatf("v%0d_bcnt", i), 32'(bus.m_bcnt), 32'd0);
      next_cycle();
    end
    bus.m_busy = '0;
    idle_in();
    next_cycle();

    // Write burst locked to slave 1, with backpressure on beat 2
    drive(8'h45, 4'd3, 1'b1, 1'b0, 8'h11);
    @(negedge clk); check_req("wb_b1", 4'b0010, 4'b0000, 1'b0); next_cycle();
    drive(8'hC0, 4'd3, 1'b1, 1'b0, 8'h22);
    bus.m_busy = 4'b0010;
    @(negedge clk); check_req("wb_b2_stall", 4'b0010, 4'b0000, 1'b1); next_cycle();
    bus.m_busy = '0;
    @(negedge clk); check_req("wb_b2", 4'b0010, 4'b0000, 1'b0); next_cycle();
    drive(8'hC0, 4'd3, 1'b1, 1'b0, 8'h33);
    @(negedge clk); check_req("wb_b3", 4'b0010, 4'b0000, 1'b0); next_cycle();
    drive(8'hC0, 4'd3, 1'b1, 1'b0, 8'h44);
    @(negedge clk); check_req("wb_b4", 4'b0010, 4'b0000, 1'b0); next_cycle();
    drive(8'hC0, 4'd0, 1'b1, 1'b0, 8'h55);
    @(negedge clk); check_req("wb_idle", 4'b1000, 4'b0000, 1'b0); next_cycle();
    idle_in();
    next_cycle();

    // Read during a write burst is stalled, then accepted once the burst ends
    drive(8'h00, 4'd1, 1'b1, 1'b0, 8'h66);
    @(negedge clk); check_req("rw_b1", 4'b0001, 4'b0000, 1'b0); next_cycle();
    drive(8'h80, 4'd1, 1'b0, 1'b1, 8'h00);
    @(negedge clk); check_req("rw_rd_stall", 4'b0000, 4'b0000, 1'b1); next_cycle();
    drive(8'h00, 4'd1, 1'b1, 1'b0, 8'h77);
    @(negedge clk); check_req("rw_b2", 4'b0001, 4'b0000, 1'b0); next_cycle();
    drive(8'h80, 4'd1, 1'b0, 1'b1, 8'h00);
    @(negedge clk); check_req("rw_rd_acc", 4'b0000, 4'b0100, 1'b0); next_cycle();

    // Read to slave 0 waits until both words from slave 2 have returned
    drive(8'h10, 4'd0, 1'b0, 1'b1, 8'h00);
    stall = 0;
    leak  = 1'b0;
    @(negedge clk);
    while (bus.s_busy && stall < 20) begin
      if (bus.m_rreq != '0) leak = 1'b1;
      stall++;
      @(negedge clk);
    end
    check("ord_stall_cycles", 32'(stall), 32'd2);
    check("ord_rreq_leak", 32'(leak), 32'd0);
    check("ord_rreq0", 32'(bus.m_rreq), 32'b0001);
    next_cycle();
    idle_in();
    drain("ord");
    check("ord_rval_total", 32'(rval_seen), 32'd3);

    // Pending limit: third read waits for the first return, admitted the cycle after the pop
    rsp_en = 1'b0;
    drive(8'hC0, 4'd0, 1'b0, 1'b1, 8'h00);
    @(negedge clk); check_req("pl_r1", 4'b0000, 4'b1000, 1'b0); next_cycle();
    @(negedge clk); check_req("pl_r2", 4'b0000, 4'b1000, 1'b0); next_cycle();
    @(negedge clk); check_req("pl_r3_full", 4'b0000, 4'b0000, 1'b1);
    rsp_en = 1'b1;
    next_cycle();
    @(negedge clk);
    check("pl_pop_rval", 32'(bus.s_rval), 32'd1);
    check_req("pl_pop", 4'b0000, 4'b0000, 1'b1);
    next_cycle();
    @(negedge clk); check_req("pl_r3_acc", 4'b0000, 4'b1000, 1'b0); next_cycle();
    idle_in();
    drain("pl");
    check("pl_rval_total", 32'(rval_seen), 32'd6);

    // Reset during a burst with two reads outstanding
    rsp_en = 1'b0;
    drive(8'h40, 4'd0, 1'b0, 1'b1, 8'h00);
    @(negedge clk); check_req("rs_r1", 4'b0000, 4'b0010, 1'b0); next_cycle();
    @(negedge clk); check_req("rs_r2", 4'b0000, 4'b0010, 1'b0); next_cycle();
    drive(8'h40, 4'd3, 1'b1, 1'b0, 8'h88);
    @(negedge clk); check_req("rs_wb1", 4'b0010, 4'b0000, 1'b0); next_cycle();
    reset = 1'b1;
    idle_in();
    sb_q.delete();
    @(negedge clk);
    check("rs_rval_a", 32'(bus.s_rval), 32'd0);
    check("rs_busy", 32'(bus.s_busy), 32'd0);
    rsp_en = 1'b1;
    next_cycle();
    @(negedge clk);
    check("rs_rval_b", 32'(bus.s_rval), 32'd0);
    next_cycle();
    reset = 1'b0;
    drain("rs_late");
    drive(8'h00, 4'd0, 1'b1, 1'b0, 8'h99);
    @(negedge clk); check_req("rs_wr0", 4'b0001, 4'b0000, 1'b0); next_cycle();
    drive(8'h00, 4'd0, 1'b0, 1'b1, 8'h00);
    @(negedge clk); check_req("rs_rd0", 4'b0000, 4'b0001, 1'b0); next_cycle();
    idle_in();
    drain("rs");
    check("end_rval_total", 32'(rval_seen), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmb_address_demux.md
Name: mmb_address_demux

Overview:
- Routes one MemoryMapped burst master to SLAVES burst slaves, selected by the upper address bits.
- It is the fan-out counterpart of the arbiter, which merges many masters into one slave; together they form an MMB interconnect.
- Write bursts are locked to the slave selected on their first beat.
- Read data is returned in request order. Reads that would reorder, or that exceed the pending limit, are stalled with s_busy.

Parameters:
- AWIDTH, 8: address width.
- DWIDTH, 8: data width.
- BWIDTH, 4: burst-count width; burst length = s_bcnt + 1 words (1..2^BWIDTH).
- SLAVES, 4: number of downstream slaves; power of two, >= 2; SELW = clog2(SLAVES).
- RDPENDS, 2: maximum outstanding read transactions (>= 1).

Ports:
- reset  in  1  asynchronous reset, active-high
- clk  in  1  clock; all state changes on the rising edge
- s_addr  in  AWIDTH  master address; slave index = s_addr[AWIDTH-1 -: SELW]
- s_bcnt  in  BWIDTH  burst count (length - 1)
- s_wreq  in  1  write request / write beat
- s_wdat  in  DWIDTH  write data
- s_rreq  in  1  read request, one cycle per burst
- s_rdat  out  DWIDTH  read data
- s_rval  out  1  read data valid
- s_busy  out  1  stall; a request is accepted when req & !s_busy
- m_addr  out  SLAVES x AWIDTH  per-slave address (copy of s_addr)
- m_bcnt  out  SLAVES x BWIDTH  per-slave burst count
- m_wreq  out  SLAVES  per-slave write request
- m_wdat  out  SLAVES x DWIDTH  per-slave write data (broadcast)
- m_rreq  out  SLAVES  per-slave read request
- m_rdat  in  SLAVES x DWIDTH  per-slave read data
- m_rval  in  SLAVES  per-slave read valid
- m_busy  in  SLAVES  per-slave stall

Behaviour:
- Reset:
  - FSM = IDLE; wsel = 0; wcnt = 0; rsel = 0; pending-length FIFO empty; rwords = 0.
  - With no requests present: s_busy = 0, s_rval = 0, s_rdat = 0, all m_wreq/m_rreq = 0.
- Request path is combinational (zero latency):
  - m_wreq[i] = s_wreq & (target == i) & write allowed.
  - m_rreq[i] = s_rreq & (target == i) & read allowed.
  - m_addr, m_bcnt, m_wdat are driven to all slaves unconditionally.
- FSM IDLE:
  - Target = address index.
  - Accepted write beat with s_bcnt == 0: single-word write, stay IDLE.
  - Accepted write beat with s_bcnt > 0: latch wsel = index, wcnt = s_bcnt, go to WRITE.
- FSM WRITE:
  - Target = wsel; s_addr and s_bcnt are ignored for routing.
  - Each accepted beat decrements wcnt; the beat accepted with wcnt == 1 returns the FSM to IDLE.
  - s_rreq is stalled: s_busy = 1 when s_rreq is asserted, m_rreq = 0.
- Read admission, IDLE only; the read is allowed iff all hold:
  - FIFO not full (fewer than RDPENDS outstanding);
  - rwords == 0, or index == rsel.
  - Otherwise s_busy = 1 and no m_rreq is issued.
- Accepted read (s_rreq & !m_busy[index]):
  - rsel = index;
  - push s_bcnt + 1 into the FIFO;
  - rwords += s_bcnt + 1, with width sufficient for RDPENDS * 2^BWIDTH.
- s_busy:
  - = m_busy[target] whenever the request itself is allowed;
  - = 1 when stalled by the rules above;
  - = 0 when neither s_wreq nor s_rreq is asserted.
- Read return:
  - s_rdat = m_rdat[rsel];
  - s_rval = m_rval[rsel] & (rwords != 0);
  - each s_rval decrements rwords and the FIFO head count;
  - when the head count reaches 0, the head is popped.
  - m_rval from any other slave is ignored.
- Same-cycle events: a push and a pop in the same cycle update rwords by (s_bcnt + 1 - 1) net. Full status uses the pre-pop count, so an accept on the pop cycle is stalled.
- s_wreq and s_rreq asserted together: the protocol forbids it. The write has priority and s_rreq is treated as stalled.
- Reset asserted mid-burst or with reads outstanding: all state is cleared immediately; late m_rval after reset is ignored.

Test Plan:
- Write burst routing:
  - Stimulus: SLAVES=4, AWIDTH=8; write s_addr=0x45, s_bcnt=3, 4 beats; s_addr changes to 0xC0 on beats 2-4.
  - Response: m_wreq[1] pulses 4 times, m_wreq[3] stays 0, FSM back to IDLE after beat 4.
- Backpressure during a burst:
  - Stimulus: m_busy[1]=1 during beat 2 of the burst above.
  - Response: s_busy=1, beat held, wcnt unchanged; beat completes on the cycle m_busy[1] falls.
- Read ordering across slaves:
  - Stimulus: read 0x80 bcnt=1, then read 0x10 bcnt=0.
  - Response: second read busy until slave 2 returns both words on s_rval; m_rreq[0] issues on the following cycle; total s_rval = 3 in order.
- Pending limit:
  - Stimulus: RDPENDS=2; three reads to 0xC0 with bcnt=0.
  - Response: first two accepted back-to-back; third busy until the first m_rval[3] is consumed, accepted one cycle later.
- Read during write:
  - Stimulus: s_rreq asserted while FSM=WRITE.
  - Response: s_busy=1, all m_rreq=0; the read is accepted once FSM=IDLE.
- Reset mid-operation:
  - Stimulus: reset asserted during a burst with 2 reads outstanding.
  - Response: s_rval=0, FSM=IDLE, rwords=0; after reset, a write to 0x00 is accepted with zero stall.
